fp_mul_arbiter: RTL and testbench
=================================

Name: fp_mul_arbiter

Overview:
- Shares one fp_mul datapath (combinational IEEE-754 single multiply: fp_X, fp_Y, r_mode -> fp_Z, ovrf, udrf) between NREQ requesters.
- Round-robin arbitration, one issue per cycle, operand/rmode registering, fixed-latency result tracking by tag.
- Returns each result to its own per-requester response FIFO. Credits make sure a result always has a FIFO slot.
- Sits between the core-side FP issue logic and the fp_mul instance.

Parameters:
- NREQ, 2, number of requesters (2..4).
- LAT, 1, cycles from operand register load to result capture; 1 = combinational multiplier, >1 = pipelined variant.
- RDEPTH, 2, per-requester response FIFO depth; also the credit limit per requester (1..8).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  request valid per requester.
- req_ready  out  NREQ  request accepted this cycle (grant & eligible).
- req_X  in  32*NREQ  operand X, slice i = requester i.
- req_Y  in  32*NREQ  operand Y.
- req_rmode  in  3*NREQ  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM.
- rsp_valid  out  NREQ  response available.
- rsp_ready  in  NREQ  response consumed.
- rsp_Z  out  32*NREQ  product.
- rsp_flags  out  3*NREQ  {bad_rmode, ovrf, udrf}.
- mul_X  out  32  to fp_mul fp_X.
- mul_Y  out  32  to fp_mul fp_Y.
- mul_r_mode  out  3  to fp_mul r_mode.
- mul_Z  in  32  from fp_mul fp_Z.
- mul_ovrf  in  1  from fp_mul.
- mul_udrf  in  1  from fp_mul.

Behaviour:
- Reset (rst=1 at edge): all FIFOs empty, rsp_valid=0. Credit counters=0. Tag pipe valid bits=0. RR pointer=0. mul_X/mul_Y/mul_r_mode=0. Operations in flight are dropped.
- Eligibility: eligible[i] = credit[i] < RDEPTH. credit[i] = in-flight ops of requester i + FIFO occupancy, width clog2(RDEPTH+1).
- Arbitration: grant goes to the first i with req_valid[i] & eligible[i], searching from the RR pointer upward and wrapping.
- req_ready is combinational: req_ready[i] = grant[i]. At most one bit is set. req_ready must not depend on req_valid of the same requester beyond the grant search.
- On accept (valid & ready at edge E0):
  - mul_X/Y/r_mode load the operands.
  - Tag {1, i, bad_rmode} enters tag pipe stage 0.
  - credit[i]++.
  - RR pointer moves to i+1 mod NREQ.
  - With no accept, the pointer holds and the mul_* registers hold their values.
- Bad rmode: req_rmode values 5..7 are issued as RNE (0), and bad_rmode=1 is carried in the tag.
- Tag pipe has LAT stages. At edge E0+LAT a valid tag writes {mul_Z, bad_rmode, mul_ovrf, mul_udrf} into FIFO[tag.id]. rsp_valid rises after E0+LAT, so accept-to-rsp_valid latency = LAT cycles.
- Back-to-back issue every cycle is sustained. For LAT>1 the multiplier is pipelined; the block does not stall.
- Pop on rsp_valid[i] & rsp_ready[i]: credit[i]--. Accept and pop of the same requester on one edge leave credit unchanged.
- FIFO write and pop on the same edge are legal at any occupancy, including full; occupancy is unchanged.
- FIFO overflow cannot occur because of credits; the bench asserts this.
- rsp_Z, rsp_flags come from the FIFO head, stable while rsp_valid=1 & rsp_ready=0.
- Requests not granted are held by the requester; the block does not latch them.

Decomposition:
- Package fp_mul_arb_pkg:
  - rmode_e enum (RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4).
  - tag_t struct {vld, id[clog2(NREQ)], bad_rmode}.
  - rsp_t struct {Z[31:0], flags[2:0]}.
  - RMODE_MAX=4.
- Sub-module fp_mul_rsp_fifo: parameterised DEPTH, rsp_t payload, wr/rd/full/empty. Instantiated NREQ times.

Test Plan:
- Single op: req0 X=32'h40400000, Y=32'h40400000, rmode=1, LAT=1, fp_mul model attached -> req_ready0=1 same cycle; rsp_valid0 one cycle after accept; rsp_Z0=32'h41100000, flags=3'b000.
- Fairness: both req_valid held high for 8 cycles, rsp_ready=all 1 -> grants alternate 0,1,0,1…; 4 results each, in issue order.
- Backpressure: rsp_ready0=0, RDEPTH=2, req0 streaming -> exactly 2 accepts, then req_ready0=0 while req1 is still granted. Raising rsp_ready0 for one cycle -> one more accept.
- Bad rmode: req1 rmode=3'b110 -> mul_r_mode=0 during issue; rsp_flags1[2]=1.
- Reset mid-flight: LAT=3, accept 3 ops, assert rst on the next edge -> rsp_valid=0, no late FIFO write, credits 0, pointer 0, next request granted to req0.
- Simultaneous pop+accept at credit=RDEPTH-1 with LAT=1 over 20 cycles -> credit never exceeds RDEPTH, no FIFO overflow assertion fires.

Source files
------------

// File: rtl/fp_mul_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_arb_pkg
// Description : Shared types and constants for the fp_mul request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_mul_arb_pkg;

    // Tag id is sized for the largest supported requester count (4).
    localparam int ID_W = 2;

    // Highest legal rounding-mode encoding; anything above is issued as RNE.
    localparam logic [2:0] RMODE_MAX = 3'd4;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } rmode_e;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
        logic            bad_rmode;
    } tag_t;

    typedef struct packed {
        logic [31:0] z;
        logic [2:0]  flags;     // {bad_rmode, ovrf, udrf}
    } rsp_t;

endpackage
`default_nettype wire

// File: rtl/fp_mul_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_rsp_fifo
// Description : Per-requester response FIFO. Simultaneous write and read are
//               allowed at any occupancy, including full.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_rsp_fifo
    import fp_mul_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_wr,
    input  rsp_t i_wdata,
    input  logic i_rd,
    output rsp_t o_rdata,
    output logic o_full,
    output logic o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    rsp_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_do_rd;
    logic             w_do_wr;

    assign o_full  = (cnt_q == CNT_FULL);
    assign o_empty = (cnt_q == '0);
    assign o_rdata = mem_q[rptr_q];

    // Pointer and occupancy update; a write into a full FIFO only lands when
    // the head is leaving on the same edge.
    always_comb begin
        w_do_rd = i_rd & ~o_empty;
        w_do_wr = i_wr & (~o_full | w_do_rd);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (w_do_wr) begin
            wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
        end
        if (w_do_rd) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(w_do_wr) - CNT_W'(w_do_rd);
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Payload storage; contents are qualified by the occupancy count.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            mem_q[wptr_q] <= i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_arbiter
// Description : Round-robin sharing of one fp_mul datapath between NREQ
//               requesters with credit-protected per-requester response FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_arbiter
    import fp_mul_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int LAT    = 1,
    parameter int RDEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_X,
    input  logic [32*NREQ-1:0]   req_Y,
    input  logic [3*NREQ-1:0]    req_rmode,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [32*NREQ-1:0]   rsp_Z,
    output logic [3*NREQ-1:0]    rsp_flags,
    output logic [31:0]          mul_X,
    output logic [31:0]          mul_Y,
    output logic [2:0]           mul_r_mode,
    input  logic [31:0]          mul_Z,
    input  logic                 mul_ovrf,
    input  logic                 mul_udrf
);

    localparam int CW  = $clog2(RDEPTH + 1);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0]  CRED_MAX = CW'(RDEPTH);
    localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);

    logic [CW-1:0]  credit_q [NREQ];
    logic [CW-1:0]  credit_d [NREQ];
    logic [IDW-1:0] rr_q, rr_d;
    tag_t           tag_q [LAT];
    tag_t           tag_d [LAT];
    logic [31:0]    mul_x_q, mul_x_d;
    logic [31:0]    mul_y_q, mul_y_d;
    logic [2:0]     mul_rm_q, mul_rm_d;

    logic [NREQ-1:0] w_eligible;
    logic [NREQ-1:0] w_grant;
    logic [NREQ-1:0] w_pop;
    logic [NREQ-1:0] w_fifo_wr;
    logic [NREQ-1:0] w_fifo_empty;
    logic [NREQ-1:0] w_fifo_full;
    logic [31:0]     w_x  [NREQ];
    logic [31:0]     w_y  [NREQ];
    logic [2:0]      w_rm [NREQ];
    logic [IDW-1:0]  w_cand;
    logic [IDW-1:0]  w_gid;
    logic            w_accept;
    logic [2:0]      w_sel_rm;
    logic            w_bad;
    rsp_t            w_wdata;
    rsp_t            w_rdata [NREQ];

    assign req_ready  = w_grant;
    assign mul_X      = mul_x_q;
    assign mul_Y      = mul_y_q;
    assign mul_r_mode = mul_rm_q;

    // The result leaving the last tag stage pairs with the multiplier output.
    assign w_wdata = '{z: mul_Z, flags: {tag_q[LAT-1].bad_rmode, mul_ovrf, mul_udrf}};

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_req
            assign w_x[i]  = req_X[32*i +: 32];
            assign w_y[i]  = req_Y[32*i +: 32];
            assign w_rm[i] = req_rmode[3*i +: 3];

            // A full FIFO already implies an exhausted credit; the extra term
            // keeps a write from ever being issued against a full FIFO.
            assign w_eligible[i] = (credit_q[i] < CRED_MAX) & ~w_fifo_full[i];
            assign w_pop[i]      = ~w_fifo_empty[i] & rsp_ready[i];
            assign w_fifo_wr[i]  = tag_q[LAT-1].vld & (tag_q[LAT-1].id == ID_W'(i));
            assign rsp_valid[i]  = ~w_fifo_empty[i];
            assign rsp_Z[32*i +: 32]    = w_rdata[i].z;
            assign rsp_flags[3*i +: 3]  = w_rdata[i].flags;

            fp_mul_rsp_fifo #(
                .DEPTH (RDEPTH)
            ) u_rsp_fifo (
                .clk     (clk),
                .rst     (rst),
                .i_wr    (w_fifo_wr[i]),
                .i_wdata (w_wdata),
                .i_rd    (w_pop[i]),
                .o_rdata (w_rdata[i]),
                .o_full  (w_fifo_full[i]),
                .o_empty (w_fifo_empty[i])
            );
        end
    endgenerate

    // Round-robin search starting at the pointer; first valid+eligible wins.
    always_comb begin
        w_grant  = '0;
        w_gid    = '0;
        w_accept = 1'b0;
        w_cand   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = IDW'((int'(rr_q) + k) % NREQ);
            if (!w_accept && req_valid[w_cand] && w_eligible[w_cand]) begin
                w_accept = 1'b1;
                w_gid    = w_cand;
            end
        end
        w_grant[w_gid] = w_accept;
    end

    // Issue path: operand capture, rounding-mode sanitising, tag pipe, pointer.
    always_comb begin
        w_sel_rm = w_rm[w_gid];
        w_bad    = (w_sel_rm > RMODE_MAX);
        mul_x_d  = mul_x_q;
        mul_y_d  = mul_y_q;
        mul_rm_d = mul_rm_q;
        rr_d     = rr_q;
        if (w_accept) begin
            mul_x_d  = w_x[w_gid];
            mul_y_d  = w_y[w_gid];
            mul_rm_d = w_bad ? RNE : w_sel_rm;
            rr_d     = (w_gid == ID_LAST) ? '0 : w_gid + 1'b1;
        end
        tag_d[0] = '{vld: w_accept, id: ID_W'(w_gid), bad_rmode: w_accept & w_bad};
        for (int k = 1; k < LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    // Credits count in-flight ops plus FIFO occupancy per requester.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            credit_d[i] = credit_q[i] + CW'(w_grant[i]) - CW'(w_pop[i]);
        end
    end

    // State registers; reset drops every operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q     <= '0;
            mul_x_q  <= '0;
            mul_y_q  <= '0;
            mul_rm_q <= '0;
            for (int k = 0; k < LAT; k++) begin
                tag_q[k] <= '0;
            end
            for (int i = 0; i < NREQ; i++) begin
                credit_q[i] <= '0;
            end
        end else begin
            rr_q     <= rr_d;
            mul_x_q  <= mul_x_d;
            mul_y_q  <= mul_y_d;
            mul_rm_q <= mul_rm_d;
            for (int k = 0; k < LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
            for (int i = 0; i < NREQ; i++) begin
                credit_q[i] <= credit_d[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_mul_arbiter
// Description : Self-checking bench: a LAT=1 instance with a scoreboard and
//               arbitration model, plus a LAT=3 instance for reset in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mul_arbiter;
    import fp_mul_arb_pkg::*;

    localparam int NREQ    = 2;
    localparam int LAT     = 1;
    localparam int RDEPTH  = 2;
    localparam int LAT3    = 3;
    localparam int RDEPTH3 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- LAT=1 instance ----------------
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
    logic [32*NREQ-1:0]  req_X = '0, req_Y = '0, rsp_Z;
    logic [3*NREQ-1:0]   req_rmode = '0, rsp_flags;
    logic [31:0]         mul_X, mul_Y, mul_Z;
    logic [2:0]          mul_r_mode;
    logic                mul_ovrf, mul_udrf;

    // ---------------- LAT=3 instance ----------------
    logic                rst3 = 1'b1;
    logic [NREQ-1:0]     v3 = '0, rdy3, rv3, rr3 = '0;
    logic [32*NREQ-1:0]  x3 = '0, y3 = '0, z3o;
    logic [3*NREQ-1:0]   rm3 = '0, f3o;
    logic [31:0]         mx3, my3, mz3;
    logic [2:0]          mrm3;
    logic                mo3, mu3;
    logic [33:0]         p3_a, p3_b;

    // Stand-in multiplier for normal operands; returns {Z, ovrf, udrf}.
    function automatic logic [33:0] fmul_ref(input logic [31:0] x, input logic [31:0] y,
                                             input logic [2:0] rm);
        logic        s, g, st, up;
        int          e;
        logic [47:0] p;
        logic [23:0] m;
        logic [24:0] mr;
        s = x[31] ^ y[31];
        p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
        e = int'(x[30:23]) + int'(y[30:23]) - 127;
        if (p[47]) begin
            m = p[47:24]; g = p[23]; st = |p[22:0]; e = e + 1;
        end else begin
            m = p[46:23]; g = p[22]; st = |p[21:0];
        end
        case (rm)
            3'd0:    up = g & (st | m[0]);
            3'd2:    up = s & (g | st);
            3'd3:    up = ~s & (g | st);
            3'd4:    up = g;
            default: up = 1'b0;
        endcase
        mr = {1'b0, m} + 25'(up);
        if (mr[24]) begin
            m = 24'h800000; e = e + 1;
        end else begin
            m = mr[23:0];
        end
        if (e >= 255) return {s, 8'hff, 23'h0, 2'b10};
        if (e <= 0)   return {s, 31'h0, 2'b01};
        return {s, e[7:0], m[22:0], 2'b00};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        v = $urandom;
        v[30:23] = 8'($urandom_range(112, 142));
        return v;
    endfunction

    assign {mul_Z, mul_ovrf, mul_udrf} = fmul_ref(mul_X, mul_Y, mul_r_mode);

    // Pipelined multiplier stand-in: LAT3-1 register stages.
    always @(posedge clk) begin
        p3_a <= fmul_ref(mx3, my3, mrm3);
        p3_b <= p3_a;
    end
    assign {mz3, mo3, mu3} = p3_b;

    fp_mul_arbiter #(.NREQ(NREQ), .LAT(LAT), .RDEPTH(RDEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_X(req_X), .req_Y(req_Y), .req_rmode(req_rmode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_Z(rsp_Z), .rsp_flags(rsp_flags),
        .mul_X(mul_X), .mul_Y(mul_Y), .mul_r_mode(mul_r_mode),
        .mul_Z(mul_Z), .mul_ovrf(mul_ovrf), .mul_udrf(mul_udrf)
    );

    fp_mul_arbiter #(.NREQ(NREQ), .LAT(LAT3), .RDEPTH(RDEPTH3)) dut3 (
        .clk(clk), .rst(rst3),
        .req_valid(v3), .req_ready(rdy3),
        .req_X(x3), .req_Y(y3), .req_rmode(rm3),
        .rsp_valid(rv3), .rsp_ready(rr3),
        .rsp_Z(z3o), .rsp_flags(f3o),
        .mul_X(mx3), .mul_Y(my3), .mul_r_mode(mrm3),
        .mul_Z(mz3), .mul_ovrf(mo3), .mul_udrf(mu3)
    );

    // ---------------- Scoreboard and arbitration model (LAT=1 DUT) ----------------
    rsp_t            sbq [NREQ][$];
    int              credit_m [NREQ];
    int              rr_m;
    logic [NREQ-1:0] m_exp_g;
    int              m_idx;
    logic [2:0]      m_rm;
    logic            m_bad;
    logic [33:0]     m_r;
    rsp_t            m_e;

    // Inputs only change just after a rising edge, so at the falling edge
    // they describe exactly what the next rising edge will see.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                sbq[i].delete();
                credit_m[i] = 0;
            end
            rr_m = 0;
        end else begin
            m_exp_g = '0;
            for (int k = 0; k < NREQ; k++) begin
                m_idx = (rr_m + k) % NREQ;
                if (m_exp_g == '0 && req_valid[m_idx] && credit_m[m_idx] < RDEPTH)
                    m_exp_g[m_idx] = 1'b1;
            end
            n_checks++;
            if (req_ready !== m_exp_g) begin
                n_fail++;
                $display("FAIL arb_grant t=%0t: req_ready=%b expected %b", $time, req_ready, m_exp_g);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (m_exp_g[i]) begin
                    m_rm  = req_rmode[3*i +: 3];
                    m_bad = (m_rm > 3'd4);
                    m_r   = fmul_ref(req_X[32*i +: 32], req_Y[32*i +: 32], m_bad ? 3'd0 : m_rm);
                    m_e   = '{z: m_r[33:2], flags: {m_bad, m_r[1], m_r[0]}};
                    sbq[i].push_back(m_e);
                    credit_m[i]++;
                    rr_m = (i + 1) % NREQ;
                end
                if (rsp_valid[i] && rsp_ready[i]) begin
                    n_checks++;
                    if (sbq[i].size() == 0) begin
                        n_fail++;
                        $display("FAIL rsp_unexpected[%0d]: got Z=%h flags=%b, expected no response",
                                 i, rsp_Z[32*i +: 32], rsp_flags[3*i +: 3]);
                    end else begin
                        m_e = sbq[i].pop_front();
                        if ({rsp_Z[32*i +: 32], rsp_flags[3*i +: 3]} !== m_e) begin
                            n_fail++;
                            $display("FAIL rsp_data[%0d]: got Z=%h flags=%b, expected Z=%h flags=%b",
                                     i, rsp_Z[32*i +: 32], rsp_flags[3*i +: 3], m_e.z, m_e.flags);
                        end
                    end
                    credit_m[i]--;
                end
                n_checks++;
                if (credit_m[i] > RDEPTH) begin
                    n_fail++;
                    $display("FAIL credit_overflow[%0d]: credit=%0d, limit %0d", i, credit_m[i], RDEPTH);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst3 = 1'b1;
        repeat (3) step();
        @(negedge clk);
        n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b, expected 00", rsp_valid); end
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b, expected 00", req_ready); end
        n_checks++; if ({mul_X, mul_Y, mul_r_mode} !== 67'd0) begin n_fail++; $display("FAIL reset_mul_regs: got X=%h Y=%h rm=%0d, expected 0", mul_X, mul_Y, mul_r_mode); end
        n_checks++; if (rv3 !== 2'b00 || mx3 !== 32'd0) begin n_fail++; $display("FAIL reset_lat3: rsp_valid=%b mul_X=%h, expected 00/0", rv3, mx3); end
        step();
        rst = 1'b0; rst3 = 1'b0;
    endtask

    task automatic test_single_op();
        step();
        rsp_ready = 2'b00;
        req_valid = 2'b01;
        req_X[31:0] = 32'h40400000; req_Y[31:0] = 32'h40400000; req_rmode[2:0] = 3'd1;
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b, expected 01", req_ready); end
        step();
        req_valid = 2'b00;
        @(negedge clk);
        n_checks++; if (mul_X !== 32'h40400000 || mul_r_mode !== 3'd1) begin n_fail++; $display("FAIL single_issue: mul_X=%h rm=%0d, expected 40400000/1", mul_X, mul_r_mode); end
        n_checks++; if (rsp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL single_early: rsp_valid0=%b, expected 0", rsp_valid[0]); end
        step();
        @(negedge clk);
        n_checks++; if (rsp_valid[0] !== 1'b1) begin n_fail++; $display("FAIL single_latency: rsp_valid0=%b, expected 1", rsp_valid[0]); end
        n_checks++; if (rsp_Z[31:0] !== 32'h41100000 || rsp_flags[2:0] !== 3'b000) begin n_fail++; $display("FAIL single_result: Z=%h flags=%b, expected 41100000/000", rsp_Z[31:0], rsp_flags[2:0]); end
        step();
        @(negedge clk);
        n_checks++; if (rsp_Z[31:0] !== 32'h41100000 || rsp_valid[0] !== 1'b1) begin n_fail++; $display("FAIL single_hold: Z=%h valid=%b, expected 41100000/1", rsp_Z[31:0], rsp_valid[0]); end
        step();
        rsp_ready = 2'b01;
        step();
        rsp_ready = 2'b00;
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] prev;
        int cnt0, cnt1;
        prev = '0; cnt0 = 0; cnt1 = 0;
        step();
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        for (int c = 0; c < 8; c++) begin
            req_X = {rand_op(), rand_op()};
            req_Y = {rand_op(), rand_op()};
            req_rmode = {3'($urandom_range(0, 4)), 3'($urandom_range(0, 4))};
            @(negedge clk);
            n_checks++;
            if (!$onehot(req_ready) || req_ready === prev) begin
                n_fail++;
                $display("FAIL fair_alternate: cycle %0d req_ready=%b previous %b, expected other single grant", c, req_ready, prev);
            end
            if (req_ready[0]) cnt0++;
            if (req_ready[1]) cnt1++;
            prev = req_ready;
            step();
        end
        req_valid = 2'b00;
        n_checks++; if (cnt0 != 4 || cnt1 != 4) begin n_fail++; $display("FAIL fair_counts: grants %0d/%0d, expected 4/4", cnt0, cnt1); end
        repeat (4) step();
    endtask

    task automatic test_backpressure();
        int acc0, acc1;
        acc0 = 0; acc1 = 0;
        rsp_ready = 2'b10;
        req_valid = 2'b11;
        for (int c = 0; c < 10; c++) begin
            req_X = {rand_op(), rand_op()};
            req_Y = {rand_op(), rand_op()};
            @(negedge clk);
            if (req_ready[0]) acc0++;
            if (req_ready[1]) acc1++;
            step();
        end
        @(negedge clk);
        n_checks++; if (acc0 != 2) begin n_fail++; $display("FAIL bp_accepts0: got %0d, expected 2", acc0); end
        n_checks++; if (acc1 < 3) begin n_fail++; $display("FAIL bp_accepts1: got %0d, expected at least 3", acc1); end
        n_checks++; if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_blocked: req_ready0=%b, expected 0", req_ready[0]); end
        step();
        acc0 = 0;
        rsp_ready = 2'b11;
        @(negedge clk);
        if (req_ready[0]) acc0++;
        step();
        rsp_ready = 2'b10;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (req_ready[0]) acc0++;
            step();
        end
        n_checks++; if (acc0 != 1) begin n_fail++; $display("FAIL bp_release: accepts %0d, expected 1", acc0); end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (6) step();
        rsp_ready = 2'b00;
    endtask

    task automatic test_bad_rmode();
        bit got;
        got = 1'b0;
        step();
        rsp_ready = 2'b00;
        req_valid = 2'b10;
        req_X[63:32] = 32'h3F800001; req_Y[63:32] = 32'h3FC00000; req_rmode[5:3] = 3'b110;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (req_ready[1]) got = 1'b1;
            else step();
        end
        n_checks++; if (!got) begin n_fail++; $display("FAIL bad_grant: req1 not granted within 10 cycles, expected grant"); end
        step();
        req_valid = 2'b00;
        @(negedge clk);
        n_checks++; if (mul_r_mode !== 3'd0 || mul_X !== 32'h3F800001) begin n_fail++; $display("FAIL bad_issue: rm=%0d X=%h, expected 0/3f800001", mul_r_mode, mul_X); end
        step();
        @(negedge clk);
        n_checks++; if (rsp_valid[1] !== 1'b1 || rsp_flags[5:3] !== 3'b100 || rsp_Z[63:32] !== 32'h3FC00002) begin
            n_fail++; $display("FAIL bad_result: valid=%b flags=%b Z=%h, expected 1/100/3fc00002", rsp_valid[1], rsp_flags[5:3], rsp_Z[63:32]);
        end
        step();
        rsp_ready = 2'b11;
        repeat (2) step();
    endtask

    task automatic test_pop_accept();
        int acc0;
        acc0 = 0;
        for (int c = 0; c < 20; c++) begin
            req_valid = {1'($urandom_range(0, 1)), 1'b1};
            rsp_ready = 2'($urandom_range(0, 3));
            if (c % 4 == 3) rsp_ready[0] = 1'b1;
            req_X = {rand_op(), rand_op()};
            req_Y = {rand_op(), rand_op()};
            req_rmode = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
            @(negedge clk);
            if (req_ready[0]) acc0++;
            step();
        end
        n_checks++; if (acc0 < 5) begin n_fail++; $display("FAIL popacc_progress: req0 accepts %0d, expected at least 5", acc0); end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (6) step();
        @(negedge clk);
        n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL drain_valid: rsp_valid=%b, expected 00", rsp_valid); end
        n_checks++; if (sbq[0].size() != 0 || sbq[1].size() != 0) begin n_fail++; $display("FAIL drain_scoreboard: pending %0d/%0d, expected 0/0", sbq[0].size(), sbq[1].size()); end
        step();
    endtask

    task automatic test_reset_midflight();
        int acc;
        step();
        rr3 = 2'b00;
        v3  = 2'b01;
        for (int c = 0; c < 3; c++) begin
            x3[31:0] = rand_op(); y3[31:0] = rand_op();
            @(negedge clk);
            n_checks++; if (rdy3 !== 2'b01) begin n_fail++; $display("FAIL mid_accept: op %0d req_ready=%b, expected 01", c, rdy3); end
            step();
        end
        v3 = 2'b00;
        rst3 = 1'b1;
        step();
        rst3 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++; if (rv3 !== 2'b00) begin n_fail++; $display("FAIL mid_late_write: cycle %0d rsp_valid=%b, expected 00", c, rv3); end
            step();
        end
        @(negedge clk);
        n_checks++; if (mx3 !== 32'd0) begin n_fail++; $display("FAIL mid_mul_reset: mul_X=%h, expected 0", mx3); end
        step();
        v3 = 2'b11;
        @(negedge clk);
        n_checks++; if (rdy3 !== 2'b01) begin n_fail++; $display("FAIL mid_pointer: req_ready=%b, expected 01", rdy3); end
        acc = 1;
        step();
        v3 = 2'b01;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rdy3[0]) acc++;
            step();
        end
        n_checks++; if (acc != RDEPTH3) begin n_fail++; $display("FAIL mid_credits: accepts %0d, expected %0d", acc, RDEPTH3); end
        v3 = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_fairness();
        test_backpressure();
        test_bad_rmode();
        test_pop_accept();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
